// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_pkg
// Shared definitions for the sequential restoring divider: the FSM state
// encoding used by the top level.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

    // ST_ILLEGAL is unreachable in normal operation; the FSM maps it back
    // to ST_IDLE so a corrupted state register cannot lock the block up.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage : seq_restoring_divider_pkg

// File: rtl/one_bit_full_adder.sv
// -----------------------------------------------------------------------------
// one_bit_full_adder
// Single-bit full adder; the building block of the ripple-carry subtractor.
// Ports:
//   a, b  in   addend bits
//   cin   in   carry in
//   sum   out  a ^ b ^ cin
//   cout  out  carry out
// -----------------------------------------------------------------------------
module one_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : one_bit_full_adder

// File: rtl/sub_rcs_n.sv
// -----------------------------------------------------------------------------
// sub_rcs_n
// N-bit ripple-carry subtractor: diff = a - b computed as a + ~b + 1.
// Ports:
//   a     in   N  minuend
//   b     in   N  subtrahend
//   diff  out  N  a - b modulo 2^N
//   nb    out  1  carry out of the top stage; 1 means no borrow (a >= b)
// -----------------------------------------------------------------------------
module sub_rcs_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         nb
);

    logic [N:0] carry;

    // Carry-in of 1 supplies the "+1" of the two's-complement negation of b.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_stage
        one_bit_full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign nb = carry[N];

endmodule : sub_rcs_n

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB
// first. A divide by zero completes in one cycle with quotient all ones,
// remainder = dividend and div_by_zero set.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request, sampled only while busy=0
//   dividend     in   WIDTH  unsigned dividend, latched on accept
//   divisor      in   WIDTH  unsigned divisor, latched on accept
//   busy         out  1      high in RUN and DONE
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result, held until the next accepted start
//   remainder    out  WIDTH  result, held until the next accepted start
//   div_by_zero  out  1      set with done when divisor was zero
// -----------------------------------------------------------------------------
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
    logic [WIDTH-1:0] dq_q,    dq_d;     // dividend, shifted out as quotient shifts in
    logic [WIDTH-1:0] dvsr_q,  dvsr_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rmd_q,   rmd_d;
    logic             dbz_q,   dbz_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             nb;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dq_next;
    logic             unused_diff_msb;

    assign trial = {rem_q, dq_q[WIDTH-1]};

    sub_rcs_n #(
        .N (WIDTH + 1)
    ) u_sub (
        .a    (trial),
        .b    ({1'b0, dvsr_q}),
        .diff (diff),
        .nb   (nb)
    );

    // When nb=1 the difference is below the divisor, so its top bit is
    // always zero and only the low WIDTH bits need keeping.
    assign unused_diff_msb = diff[WIDTH];
    assign rem_next        = nb ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_next         = {dq_q[WIDTH-2:0], nb};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor != '0) begin
                        state_d = ST_RUN;
                        dq_d    = dividend;
                        dvsr_d  = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                rem_d  = rem_next;
                dq_d   = dq_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    quot_d  = dq_next;
                    rmd_d   = rem_next;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider
